// File: rtl/clock_counter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | clock_counter : BCD time-of-day counter (HH:MM:SS.FF) driven by a CE tick, |
// |   with 12/24 h display, validated load, set keys and day pulse.            |
// | Optional alarm comparator: define CLOCK_COUNTER_ALARM_EN.                  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module clock_counter #(
  parameter int FRAC_MOD = 100,
  parameter int RST_HOUR = 0
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        CE,
  input  logic        SETH,
  input  logic        SETM,
  input  logic        SCLR,
  input  logic        MODE24,
  input  logic        LOAD,
  input  logic [31:0] LOAD_TIME,
  input  logic [15:0] ALM_TIME,
  input  logic        ALM_ACK,
  output logic [31:0] TIME,
  output logic        PM,
  output logic        DAY,
  output logic        LDERR,
  output logic        ALARM
);

  localparam logic [7:0] c_ff_last = (FRAC_MOD == 10) ? 8'h09 : 8'h99;
  localparam logic [7:0] c_rst_hh  = 8'(((RST_HOUR / 10) * 16) + (RST_HOUR % 10));

  function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] last);
    if (v == last)
      bcd_inc = 8'h00;
    else if (v[3:0] == 4'd9)
      bcd_inc = {v[7:4] + 4'd1, 4'd0};
    else
      bcd_inc = v + 8'd1;
  endfunction

  function automatic logic nibs_ok(input logic [31:0] v);
    nibs_ok = 1'b1;
    for (int i = 0; i < 8; i++)
      if (v[4*i +: 4] > 4'd9)
        nibs_ok = 1'b0;
  endfunction

  logic [7:0] r_hh, r_mm, r_ss, r_ff;
  logic       r_day, r_lderr;
  logic [7:0] w_nxt_hh, w_nxt_mm, w_nxt_ss, w_nxt_ff;
  logic       w_day;
  logic       w_ld_ok;
  logic       w_sec_tick;
  logic       w_mm_carry;
  logic [7:0] w_h12;

  // BCD byte compares are numeric once every nibble is known to be 0..9
  assign w_ld_ok = nibs_ok(LOAD_TIME) &&
                   (LOAD_TIME[31:24] <= 8'h23) && (LOAD_TIME[23:16] <= 8'h59) &&
                   (LOAD_TIME[15:8]  <= 8'h59) && (LOAD_TIME[7:0]   <= c_ff_last);

  assign w_sec_tick = CE && (r_ff == c_ff_last);
  assign w_mm_carry = (r_ss == 8'h59) && (r_mm == 8'h59);

  always_comb begin
    w_nxt_hh = r_hh;
    w_nxt_mm = r_mm;
    w_nxt_ss = r_ss;
    w_nxt_ff = r_ff;
    w_day    = 1'b0;
    if (LOAD && w_ld_ok) begin
      {w_nxt_hh, w_nxt_mm, w_nxt_ss, w_nxt_ff} = LOAD_TIME;
    end else if (SCLR) begin
      w_nxt_ss = 8'h00;
      w_nxt_ff = 8'h00;
    end else if (CE) begin
      w_nxt_ff = bcd_inc(r_ff, c_ff_last);
      if (w_sec_tick) begin
        w_nxt_ss = bcd_inc(r_ss, 8'h59);
        // set keys share the increment with a natural carry, so a field moves once
        if ((r_ss == 8'h59) || SETM)
          w_nxt_mm = bcd_inc(r_mm, 8'h59);
        if (w_mm_carry || SETH)
          w_nxt_hh = bcd_inc(r_hh, 8'h23);
        w_day = w_mm_carry && (r_hh == 8'h23);
      end
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_hh    <= c_rst_hh;
      r_mm    <= 8'h00;
      r_ss    <= 8'h00;
      r_ff    <= 8'h00;
      r_day   <= 1'b0;
      r_lderr <= 1'b0;
    end else begin
      r_hh    <= w_nxt_hh;
      r_mm    <= w_nxt_mm;
      r_ss    <= w_nxt_ss;
      r_ff    <= w_nxt_ff;
      r_day   <= w_day;
      r_lderr <= LOAD && !w_ld_ok;
    end
  end

  always_comb begin
    w_h12 = r_hh;
    case (r_hh)
      8'h00:   w_h12 = 8'h12;
      8'h13:   w_h12 = 8'h01;
      8'h14:   w_h12 = 8'h02;
      8'h15:   w_h12 = 8'h03;
      8'h16:   w_h12 = 8'h04;
      8'h17:   w_h12 = 8'h05;
      8'h18:   w_h12 = 8'h06;
      8'h19:   w_h12 = 8'h07;
      8'h20:   w_h12 = 8'h08;
      8'h21:   w_h12 = 8'h09;
      8'h22:   w_h12 = 8'h10;
      8'h23:   w_h12 = 8'h11;
      default: w_h12 = r_hh;
    endcase
  end

  assign TIME  = {(MODE24 ? r_hh : w_h12), r_mm, r_ss, r_ff};
  assign PM    = (r_hh >= 8'h12);
  assign DAY   = r_day;
  assign LDERR = r_lderr;

`ifdef CLOCK_COUNTER_ALARM_EN
  logic r_alarm;
  logic w_alm_ok, w_moved, w_alm_hit;

  assign w_alm_ok  = nibs_ok({ALM_TIME, 16'h0000}) &&
                     (ALM_TIME[15:8] <= 8'h23) && (ALM_TIME[7:0] <= 8'h59);
  assign w_moved   = {w_nxt_hh, w_nxt_mm, w_nxt_ss, w_nxt_ff} != {r_hh, r_mm, r_ss, r_ff};
  assign w_alm_hit = w_alm_ok && w_moved &&
                     ({w_nxt_hh, w_nxt_mm, w_nxt_ss, w_nxt_ff} == {ALM_TIME, 16'h0000});

  // a hit moves min too, so it must outrank the one-minute auto clear
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST)
      r_alarm <= 1'b0;
    else if (ALM_ACK)
      r_alarm <= 1'b0;
    else if (w_alm_hit)
      r_alarm <= 1'b1;
    else if (w_nxt_mm != r_mm)
      r_alarm <= 1'b0;
  end

  assign ALARM = r_alarm;
`else
  logic w_unused_alm;
  assign w_unused_alm = ^{ALM_TIME, ALM_ACK};
  assign ALARM = 1'b0;
`endif

endmodule
`default_nettype wire
